fft_sequencer: RTL
==================

Name: fft_sequencer

Overview:
- Control FSM and address generator for the in-place radix-2 DIT FFT register bank (N complex 16-bit words, inputs already bit-reverse routed).
- Accepts a start pulse and pulses the bank load enable.
- Walks all LOG2_N stages, issuing one butterfly (index pair plus twiddle index) per accepted handshake.
- Inserts drain gaps between stages and pulses done; replaces ad-hoc stage/count/twiddle counters.

Parameters:
- N_POINTS, 64, FFT length (power of 2, >=4)
- LOG2_N, 6, log2(N_POINTS)
- STAGE_GAP, 2, idle cycles after each stage's last butterfly for datapath write-back (0 allowed)

Ports:
- clk  in  1  clock; all flops update on falling edge
- rst  in  1  asynchronous active-low reset
- start  in  1  request a transform; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no done
- bfly_ready  in  1  datapath accepts current butterfly
- load_en  out  1  one-cycle pulse: bank captures input samples
- bfly_valid  out  1  idx_a/idx_b/tw_idx valid
- idx_a  out  LOG2_N  upper-butterfly register index
- idx_b  out  LOG2_N  lower-butterfly register index (idx_a + 2^stage)
- tw_idx  out  LOG2_N-1  twiddle exponent k of W_N^k
- stage  out  $clog2(LOG2_N)  current stage, 0..LOG2_N-1
- busy  out  1  high from load_en through done inclusive
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; internal counters 0.
- Reset mid-transform: immediate return to IDLE with no done; bank contents are not touched by this block.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE:
  - start=1 -> LOAD.
  - start is ignored in every other state; no queuing.
- LOAD: load_en=1, busy=1 for exactly one cycle -> RUN, with stage=0 and k=0.
- RUN: bfly_valid=1.
  - Butterfly counter k (LOG2_N-1 bits) advances only when bfly_valid & bfly_ready.
  - bfly_ready=0 holds all outputs stable.
- Addressing, with s=stage, h=2^s, grp=k>>s, pos=k&(h-1):
  - idx_a = (grp<<(s+1)) | pos
  - idx_b = idx_a + h
  - tw_idx = pos << (LOG2_N-1-s)
  - All arithmetic is unsigned, truncated to port width.
- End of stage: on acceptance of k=N/2-1, k wraps to 0.
  - STAGE_GAP>0: go to GAP (bfly_valid=0) for exactly STAGE_GAP cycles.
  - STAGE_GAP=0: skip GAP.
- Next stage: after the gap, if stage<LOG2_N-1, stage increments and the FSM returns to RUN. Otherwise -> DONE.
- Drain gap: the gap also follows the final stage.
- DONE: done=1, busy=1 for one cycle -> IDLE; stage and indices return to 0.
- abort=1 in LOAD, RUN, GAP or DONE:
  - Next edge -> IDLE, outputs cleared, no done.
  - abort has priority over bfly_ready in the same cycle.
  - abort in IDLE has no effect and overrides a simultaneous start.
- Latency with bfly_ready tied 1:
  - First bfly_valid is the cycle after load_en.
  - done is asserted LOG2_N*(N_POINTS/2+STAGE_GAP)+1 cycles after the load_en cycle (205 for defaults).
- Each index pair appears exactly once per stage; idx_a < idx_b always; no index repeats within a stage.
- Outputs are registered (no combinational path from bfly_ready to idx_*).

Test Plan:
- Reset then start pulse, bfly_ready=1 -> load_en one cycle; stage 0 issues (0,1,tw0),(2,3,tw0)...(62,63,tw0); done exactly 205 cycles after load_en; busy low the cycle after done.
- Stage 2 trace (s=2) -> k=0..5 give idx_a=0,1,2,3,8,9; idx_b=4,5,6,7,12,13; tw_idx=0,8,16,24,0,8; stage 5 k=31 gives (31,63,tw 31).
- Randomly toggle bfly_ready (about 50%) -> outputs held while ready=0; every stage still covers all 32 unique pairs; total accepted butterflies=192; single done.
- start re-pulsed during RUN and GAP -> ignored, no second load_en; start in the cycle after done -> new transform with load_en next cycle.
- abort mid-stage 3 -> IDLE next edge, bfly_valid=0, no done; rst asserted low asynchronously mid-RUN -> all outputs 0 immediately.
- STAGE_GAP=0, N_POINTS=8, LOG2_N=3 -> 12 contiguous bfly_valid cycles, done 13 cycles after load_en.

Source files
------------

// File: rtl/fft_sequencer_if.sv
// Handshake and address bundle between the FFT sequencer and the butterfly datapath/bank.
interface fft_sequencer_if #(
  parameter int LOG2_N = 6
);
  localparam int SW = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

  logic              start;
  logic              abort;
  logic              bfly_ready;
  logic              load_en;
  logic              bfly_valid;
  logic [LOG2_N-1:0] idx_a;
  logic [LOG2_N-1:0] idx_b;
  logic [LOG2_N-2:0] tw_idx;
  logic [SW-1:0]     stage;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, bfly_ready,
    output load_en, bfly_valid, idx_a, idx_b, tw_idx, stage, busy, done
  );

  modport slave (
    output start, abort, bfly_ready,
    input  load_en, bfly_valid, idx_a, idx_b, tw_idx, stage, busy, done
  );
endinterface

// File: rtl/fft_sequencer.sv
// Control FSM and butterfly address generator for an in-place radix-2 DIT FFT register bank.
//
// state  | meaning
// S_IDLE | waiting for start
// S_LOAD | one-cycle load_en pulse into the bank
// S_RUN  | issuing butterflies of the current stage, one per accepted handshake
// S_GAP  | write-back drain after a stage's last butterfly
// S_DONE | one-cycle completion pulse
module fft_sequencer #(
  parameter int N_POINTS  = 64,
  parameter int LOG2_N    = 6,
  parameter int STAGE_GAP = 2
) (
  input logic             clk,
  input logic             rst,
  fft_sequencer_if.master bus
);

  localparam int SW = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
  localparam int KW = LOG2_N - 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int AW = 3 * LOG2_N - 1;

  localparam logic [KW-1:0] K_LAST     = KW'(N_POINTS / 2 - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2_N - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [SW-1:0]   stage_q, stage_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [AW-1:0]   addr_nxt;

  logic              load_en_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [LOG2_N-1:0] idx_a_q;
  logic [LOG2_N-1:0] idx_b_q;
  logic [KW-1:0]     tw_q;

  // grp<<(s+1) equals (k with its low s bits cleared)<<1, so no variable right shift is needed.
  function automatic logic [AW-1:0] bfly_addr(input logic [KW-1:0] kin, input logic [SW-1:0] s);
    logic [LOG2_N-1:0] kx;
    logic [LOG2_N-1:0] mask;
    logic [LOG2_N-1:0] pos;
    logic [LOG2_N-1:0] a;
    logic [LOG2_N-1:0] b;
    logic [KW-1:0]     tw;
    kx   = {1'b0, kin};
    mask = (LOG2_N'(1) << s) - LOG2_N'(1);
    pos  = kx & mask;
    a    = ((kx & ~mask) << 1) | pos;
    b    = a + (LOG2_N'(1) << s);
    tw   = KW'(pos << (LAST_STAGE - s));
    return {a, b, tw};
  endfunction

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      k         <= '0;
      stage_q   <= '0;
      gap_cnt   <= '0;
      load_en_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      tw_q      <= '0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      stage_q   <= stage_nxt;
      gap_cnt   <= gap_nxt;
      load_en_q <= (state_nxt == S_LOAD);
      valid_q   <= (state_nxt == S_RUN);
      busy_q    <= (state_nxt != S_IDLE);
      done_q    <= (state_nxt == S_DONE);
      {idx_a_q, idx_b_q, tw_q} <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    stage_nxt = stage_q;
    gap_nxt   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_RUN;
        k_nxt     = '0;
        stage_nxt = '0;
      end
      S_RUN: begin
        if (bus.bfly_ready) begin
          if (k == K_LAST) begin
            k_nxt = '0;
            if (STAGE_GAP > 0) begin
              state_nxt = S_GAP;
              gap_nxt   = GAP_LOAD;
            end else if (stage_q == LAST_STAGE) begin
              state_nxt = S_DONE;
            end else begin
              stage_nxt = stage_q + 1'b1;
            end
          end else begin
            k_nxt = k + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          if (stage_q == LAST_STAGE) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
            stage_nxt = stage_q + 1'b1;
          end
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        stage_nxt = '0;
        k_nxt     = '0;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over the handshake and, in IDLE, over a simultaneous start.
    if (bus.abort) begin
      state_nxt = S_IDLE;
      k_nxt     = '0;
      stage_nxt = '0;
      gap_nxt   = '0;
    end

    addr_nxt = (state_nxt == S_RUN) ? bfly_addr(k_nxt, stage_nxt) : '0;
  end

  assign bus.load_en    = load_en_q;
  assign bus.bfly_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.idx_a      = idx_a_q;
  assign bus.idx_b      = idx_b_q;
  assign bus.tw_idx     = tw_q;
  assign bus.stage      = stage_q;

endmodule
